// File: rtl/hd_codeword_rx.sv
// Serial-to-parallel collector that packs 14 MSB-first bits into two Hamming(7,4) code words.
// One registered output pair; frames realign on in_sync, and any partial frame is dropped and flagged.
module hd_codeword_rx #(
   parameter int CW_W  = 7,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_data,
   input  logic             in_sync,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW_W-1:0]  code_word1,
   output logic [CW_W-1:0]  code_word2,
   output logic             frame_drop,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int FB = 2 * CW_W;
   localparam int BW = $clog2(FB);
   localparam logic [BW-1:0] LAST = BW'(FB - 1);

   logic [BW-1:0] bit_cnt;
   logic [FB-2:0] shift;
   logic [FB-1:0] frame;
   logic          accept;
   logic          last_bit;
   logic          restart;
   logic          complete;

   // The last bit may only enter when the output slot is free or draining this cycle.
   assign last_bit = (bit_cnt == LAST);
   assign in_ready = !(last_bit && out_valid && !out_ready);
   assign accept   = in_valid && in_ready;
   assign restart  = accept && in_sync;
   assign complete = accept && !in_sync && last_bit;
   assign frame    = {shift, in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         shift      <= '0;
         frame_drop <= 1'b0;
      end else begin
         frame_drop <= restart && (bit_cnt != '0);
         if (restart) begin
            bit_cnt <= BW'(1);
            shift   <= {{(FB-2){1'b0}}, in_data};
         end else if (complete) begin
            bit_cnt <= '0;
            shift   <= '0;
         end else if (accept) begin
            bit_cnt <= bit_cnt + BW'(1);
            shift   <= {shift[FB-3:0], in_data};
         end
      end
   end

   // A completing frame reloads the slot even when the previous pair drains on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         code_word1 <= '0;
         code_word2 <= '0;
         frame_cnt  <= '0;
      end else if (complete) begin
         out_valid  <= 1'b1;
         code_word1 <= frame[FB-1:CW_W];
         code_word2 <= frame[CW_W-1:0];
         if (frame_cnt != '1) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hd_codeword_rx.sv
// Self-checking bench for hd_codeword_rx: directed scenarios plus a randomized stream scored against a frame-level model.
module tb_hd_codeword_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_data = 1'b0;
   logic       in_sync = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [6:0] code_word1;
   logic [6:0] code_word2;
   logic       frame_drop;
   logic [7:0] frame_cnt;

   int pass_cnt = 0;
   int total_cnt = 0;

   hd_codeword_rx #(.CW_W(7), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sync    (in_sync),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .code_word1 (code_word1),
      .code_word2 (code_word2),
      .frame_drop (frame_drop),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Presents one bit until the DUT takes it; returns 1 time unit after the accepting edge.
   task automatic send_bit(input logic b, input logic s);
      int n;
      in_valid = 1'b1;
      in_data  = b;
      in_sync  = s;
      #1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         total_cnt++;
         $display("FAIL send_bit_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sync  = 1'b0;
      in_data  = 1'($urandom);
   endtask

   task automatic send_frame(input logic [6:0] a, input logic [6:0] b, input int gap, input logic sync_first);
      logic [13:0] f;
      f = {a, b};
      for (int i = 0; i < 14; i++) begin
         send_bit(f[13-i], sync_first && (i == 0));
         if (i < 13) begin
            repeat (gap) begin
               in_data = 1'($urandom);
               @(posedge clk); #1;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else pass_cnt++;
      do_reset();
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else pass_cnt++;
      total_cnt++;
      if ({code_word1, code_word2} !== 14'h0) $display("FAIL reset_words: got %h/%h required 00/00", code_word1, code_word2); else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'h00) $display("FAIL reset_frame_cnt: got %h required 00", frame_cnt); else pass_cnt++;
      total_cnt++;
      if (frame_drop !== 1'b0) $display("FAIL reset_frame_drop: got %b required 0", frame_drop); else pass_cnt++;
   endtask

   task automatic test_single_frame();
      logic [13:0] f;
      do_reset();
      out_ready = 1'b1;
      f = {7'b1010101, 7'b0110011};
      for (int i = 0; i < 13; i++) send_bit(f[13-i], 1'b0);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b required 0", out_valid); else pass_cnt++;
      send_bit(f[0], 1'b0);
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL single_valid: got %b required 1", out_valid); else pass_cnt++;
      total_cnt++;
      if ({code_word1, code_word2} !== f) $display("FAIL single_words: got %b/%b required 1010101/0110011", code_word1, code_word2); else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd1) $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL single_valid_drop: got %b required 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [13:0] fa, fb;
      fa = {7'h35, 7'h4A};
      fb = {7'h0F, 7'h71};
      do_reset();
      out_ready = 1'b0;
      send_frame(fa[13:7], fa[6:0], 0, 1'b0);
      for (int i = 0; i < 13; i++) send_bit(fb[13-i], 1'b0);
      in_valid = 1'b1;
      in_data  = fb[0];
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL b2b_ready_low: got %b required 0", in_ready); else pass_cnt++;
      repeat (3) begin
         @(posedge clk); #1;
         total_cnt++;
         if ({out_valid, code_word1, code_word2} !== {1'b1, fa})
            $display("FAIL b2b_hold: got %b %h/%h required 1 %h/%h", out_valid, code_word1, code_word2, fa[13:7], fa[6:0]);
         else pass_cnt++;
      end
      out_ready = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL b2b_ready_high: got %b required 1", in_ready); else pass_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total_cnt++;
      if ({out_valid, code_word1, code_word2} !== {1'b1, fb})
         $display("FAIL b2b_second_pair: got %b %h/%h required 1 %h/%h", out_valid, code_word1, code_word2, fb[13:7], fb[6:0]);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd2) $display("FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b required 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_sync();
      logic [13:0] f;
      do_reset();
      out_ready = 1'b1;
      repeat (5) send_bit(1'($urandom), 1'b0);
      f = {7'h7F, 7'h00};
      send_bit(f[13], 1'b1);
      total_cnt++;
      if (frame_drop !== 1'b1) $display("FAIL sync_drop_pulse: got %b required 1", frame_drop); else pass_cnt++;
      for (int i = 1; i < 14; i++) begin
         send_bit(f[13-i], 1'b0);
         if (i == 1) begin
            total_cnt++;
            if (frame_drop !== 1'b0) $display("FAIL sync_drop_one_cycle: got %b required 0", frame_drop); else pass_cnt++;
         end
      end
      total_cnt++;
      if ({out_valid, code_word1, code_word2} !== {1'b1, f})
         $display("FAIL sync_words: got %b %h/%h required 1 7f/00", out_valid, code_word1, code_word2);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd1) $display("FAIL sync_frame_cnt: got %0d required 1", frame_cnt); else pass_cnt++;

      // sync on the first bit of a frame is not a drop
      f = {7'h12, 7'h6D};
      send_bit(f[13], 1'b1);
      total_cnt++;
      if (frame_drop !== 1'b0) $display("FAIL sync_at_zero: got %b required 0", frame_drop); else pass_cnt++;
      for (int i = 1; i < 14; i++) send_bit(f[13-i], 1'b0);
      total_cnt++;
      if ({code_word1, code_word2} !== f) $display("FAIL sync_at_zero_words: got %h/%h required 12/6d", code_word1, code_word2); else pass_cnt++;

      // sync with in_valid low is ignored
      f = {7'h2B, 7'h54};
      for (int i = 0; i < 4; i++) send_bit(f[13-i], 1'b0);
      in_sync = 1'b1;
      @(posedge clk); #1;
      in_sync = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (frame_drop !== 1'b0) $display("FAIL sync_no_valid_drop: got %b required 0", frame_drop); else pass_cnt++;
      for (int i = 4; i < 14; i++) send_bit(f[13-i], 1'b0);
      total_cnt++;
      if ({out_valid, code_word1, code_word2} !== {1'b1, f})
         $display("FAIL sync_no_valid_words: got %b %h/%h required 1 2b/54", out_valid, code_word1, code_word2);
      else pass_cnt++;

      // sync on the would-be last bit drops the frame instead of completing it
      f = {7'h66, 7'h19};
      repeat (13) send_bit(1'($urandom), 1'b0);
      send_bit(f[13], 1'b1);
      total_cnt++;
      if ({frame_drop, out_valid} !== 2'b10) $display("FAIL sync_last_bit: got drop=%b valid=%b required drop=1 valid=0", frame_drop, out_valid); else pass_cnt++;
      for (int i = 1; i < 14; i++) send_bit(f[13-i], 1'b0);
      total_cnt++;
      if ({code_word1, code_word2} !== f) $display("FAIL sync_last_bit_words: got %h/%h required 66/19", code_word1, code_word2); else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd4) $display("FAIL sync_total_frames: got %0d required 4", frame_cnt); else pass_cnt++;
   endtask

   task automatic test_gapped();
      do_reset();
      out_ready = 1'b1;
      send_frame(7'b0001111, 7'b1110000, 2, 1'b0);
      total_cnt++;
      if ({out_valid, code_word1, code_word2} !== {1'b1, 7'b0001111, 7'b1110000})
         $display("FAIL gapped_words: got %b %b/%b required 1 0001111/1110000", out_valid, code_word1, code_word2);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd1) $display("FAIL gapped_frame_cnt: got %0d required 1", frame_cnt); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      send_frame(7'h55, 7'h2A, 0, 1'b0);
      repeat (9) send_bit(1'($urandom), 1'b0);
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL areset_precondition: got %b required 1", out_valid); else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, code_word1, code_word2, frame_cnt} !== 23'h0)
         $display("FAIL areset_clear: got %b %h/%h cnt=%0d required 0 00/00 cnt=0", out_valid, code_word1, code_word2, frame_cnt);
      else pass_cnt++;
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      send_frame(7'h3C, 7'h43, 0, 1'b0);
      total_cnt++;
      if ({out_valid, code_word1, code_word2} !== {1'b1, 7'h3C, 7'h43})
         $display("FAIL areset_clean_frame: got %b %h/%h required 1 3c/43", out_valid, code_word1, code_word2);
      else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd1) $display("FAIL areset_frame_cnt: got %0d required 1", frame_cnt); else pass_cnt++;
   endtask

   // Frame-level model: queue of bits to send, queue of completed-but-undelivered pairs.
   task automatic test_random();
      logic [13:0] src_q[$];
      logic [13:0] exp_q[$];
      logic        bit_q[$];
      logic [13:0] f;
      logic        exp_rdy;
      int          acc;
      int          cycles;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         f = 14'($urandom);
         src_q.push_back(f);
         for (int i = 13; i >= 0; i--) bit_q.push_back(f[i]);
      end
      acc = 0;
      cycles = 0;
      while ((bit_q.size() != 0 || exp_q.size() != 0) && cycles < 3000) begin
         in_valid  = (bit_q.size() != 0) && ($urandom_range(3) != 0);
         in_data   = in_valid ? bit_q[0] : 1'($urandom);
         out_ready = 1'($urandom);
         #1;
         exp_rdy = !(acc == 13 && exp_q.size() != 0 && !out_ready);
         total_cnt++;
         if (out_valid !== (exp_q.size() != 0)) $display("FAIL rand_out_valid: got %b required %b", out_valid, exp_q.size() != 0); else pass_cnt++;
         total_cnt++;
         if (in_ready !== exp_rdy) $display("FAIL rand_in_ready: got %b required %b", in_ready, exp_rdy); else pass_cnt++;
         if (exp_q.size() != 0 && out_ready) begin
            total_cnt++;
            if ({code_word1, code_word2} !== exp_q[0])
               $display("FAIL rand_words: got %h/%h required %h/%h", code_word1, code_word2, exp_q[0][13:7], exp_q[0][6:0]);
            else pass_cnt++;
            void'(exp_q.pop_front());
         end
         if (in_valid && exp_rdy) begin
            void'(bit_q.pop_front());
            acc++;
            if (acc == 14) begin
               acc = 0;
               exp_q.push_back(src_q.pop_front());
            end
         end
         @(posedge clk); #1;
         cycles++;
      end
      in_valid = 1'b0;
      total_cnt++;
      if (bit_q.size() != 0 || exp_q.size() != 0) $display("FAIL rand_timeout: %0d bits and %0d pairs left required 0", bit_q.size(), exp_q.size()); else pass_cnt++;
      total_cnt++;
      if (frame_cnt !== 8'd8) $display("FAIL rand_frame_cnt: got %0d required 8", frame_cnt); else pass_cnt++;
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b1;
      for (int n = 1; n <= 257; n++) begin
         send_frame(7'($urandom), 7'($urandom), 0, 1'b0);
         if (n == 254 || n == 255 || n == 257) begin
            total_cnt++;
            if (frame_cnt !== ((n > 255) ? 8'hFF : 8'(n)))
               $display("FAIL saturation_%0d: got %h required %h", n, frame_cnt, (n > 255) ? 8'hFF : 8'(n));
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_sync();
      test_gapped();
      test_async_reset();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
